// File: rtl/adpcm_enc_feeder_if.sv
// Stream, codec and packer signal bundle for adpcm_enc_feeder.
// The feeder uses the master modport; neighbours/bench use slave.
interface adpcm_enc_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_pcm;
    logic        codec_req;
    logic        codec_ack;
    logic [15:0] codec_pcm;
    logic [3:0]  codec_adpcm;
    logic        pack_push;
    logic [3:0]  pack_adpcm;
    logic        pack_full;

    modport master (
        input  s_valid, s_pcm, codec_ack, codec_adpcm, pack_full,
        output s_ready, codec_req, codec_pcm, pack_push, pack_adpcm
    );

    modport slave (
        output s_valid, s_pcm, codec_ack, codec_adpcm, pack_full,
        input  s_ready, codec_req, codec_pcm, pack_push, pack_adpcm
    );
endinterface

// File: rtl/adpcm_enc_feeder.sv
// adpcm_enc_feeder: buffers PCM samples in a small FIFO, hands them one at a
// time to the adpcm encoder (toggle req / level ack), and forwards each 4-bit
// code to the nibble packer with a toggle push, waiting while it is full.
// A per-sample watchdog aborts a codec that never completes.
module adpcm_enc_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    adpcm_enc_feeder_if.master     bus,
    input  logic                   clr_err,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_BUSY = 3'd2,
        S_DONE = 3'd3,
        S_PUSH = 3'd4
    } state_t;

    // FIFO state
    logic [15:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             s_ready_r;

    // Sequencer state and registered outputs
    state_t           state_r;
    logic             codec_req_r;
    logic [15:0]      codec_pcm_r;
    logic             pack_push_r;
    logic [3:0]       pack_adpcm_r;
    logic             err_r;
    logic [CNT_W-1:0] tmo_cnt_r;

    // Combinational helpers
    logic             wr_en_s;
    logic             pop_s;
    logic [LVL_W-1:0] level_nxt_s;
    logic [CNT_W-1:0] tmo_cnt_inc_s;
    logic             tmo_hit_s;

    // Handshake qualification, next occupancy and watchdog compare
    always_comb begin
        wr_en_s       = enable & bus.s_valid & s_ready_r;
        pop_s         = enable & (state_r == S_IDLE) &
                        (level_r != {LVL_W{1'b0}}) & bus.codec_ack;
        tmo_cnt_inc_s = tmo_cnt_r + CNT_ONE;
        tmo_hit_s     = (tmo_cnt_inc_s == TIMEOUT_L);
        level_nxt_s   = level_r;
        case ({wr_en_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage, wrapping pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            level_r   <= {LVL_W{1'b0}};
            s_ready_r <= 1'b1;
        end else if (enable) begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= bus.s_pcm;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // Full is judged from occupancy so pointer equality is never ambiguous
            level_r   <= level_nxt_s;
            s_ready_r <= (level_nxt_s < DEPTH_L);
        end
    end

    // Sample sequencer: codec handshake, packer push, watchdog and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= S_IDLE;
            codec_req_r  <= 1'b0;
            codec_pcm_r  <= 16'h0000;
            pack_push_r  <= 1'b0;
            pack_adpcm_r <= 4'h0;
            err_r        <= 1'b0;
            tmo_cnt_r    <= {CNT_W{1'b0}};
        end else if (enable) begin
            // A timeout set later in this block overrides the clear
            if (clr_err) begin
                err_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        codec_pcm_r <= mem_r[rd_ptr_r];
                        state_r     <= S_REQ;
                    end
                end
                S_REQ: begin
                    codec_req_r <= ~codec_req_r;
                    tmo_cnt_r   <= {CNT_W{1'b0}};
                    state_r     <= S_BUSY;
                end
                S_BUSY: begin
                    tmo_cnt_r <= tmo_cnt_inc_s;
                    if (tmo_hit_s) begin
                        // Abort: sample dropped, req left as is
                        err_r   <= 1'b1;
                        state_r <= S_IDLE;
                    end else if (!bus.codec_ack) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    tmo_cnt_r <= tmo_cnt_inc_s;
                    if (tmo_hit_s) begin
                        err_r   <= 1'b1;
                        state_r <= S_IDLE;
                    end else if (bus.codec_ack) begin
                        pack_adpcm_r <= bus.codec_adpcm;
                        state_r      <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // No watchdog here: the packer may legitimately stall
                    if (!bus.pack_full) begin
                        pack_push_r <= ~pack_push_r;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready    = s_ready_r;
    assign bus.codec_req  = codec_req_r;
    assign bus.codec_pcm  = codec_pcm_r;
    assign bus.pack_push  = pack_push_r;
    assign bus.pack_adpcm = pack_adpcm_r;
    assign err            = err_r;
    assign level          = level_r;
endmodule

// File: tb/tb_adpcm_enc_feeder.sv
// Self-checking bench for adpcm_enc_feeder: 8-state codec model, packer
// push monitor and an expected-code scoreboard.
`timescale 1ns/1ps
module tb_adpcm_enc_feeder;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk     = 1'b0;
    logic       rstn    = 1'b0;
    logic       enable  = 1'b1;
    logic       clr_err = 1'b0;
    logic       err;
    logic [3:0] level;

    adpcm_enc_feeder_if bus_if();

    adpcm_enc_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .bus     (bus_if),
        .clr_err (clr_err),
        .err     (err),
        .level   (level)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_code_q[$];
    int         obs_cyc_q[$];

    logic       stuck = 1'b0;
    logic       last_push;
    logic       seen_req;
    logic [3:0] busy_cnt;

    function automatic logic [3:0] code_of(input logic [15:0] p);
        return p[11:8] ^ p[3:0] ^ 4'h6;
    endfunction

    function automatic logic [15:0] smp_of(input int i);
        logic [31:0] t;
        t = 32'h0000_0137 * (i + 1) + 32'h0000_0040;
        return t[15:0];
    endfunction

    // Clock
    always #5 clk = ~clk;

    // Edge counter used as the cycle timestamp
    always @(posedge clk) cyc <= cyc + 1;

    // Codec model: drops ack the edge after a req toggle, raises it 7 edges later
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_if.codec_ack   <= 1'b1;
            bus_if.codec_adpcm <= 4'h0;
            seen_req           <= 1'b0;
            busy_cnt           <= 4'd0;
        end else if (bus_if.codec_req !== seen_req) begin
            seen_req <= bus_if.codec_req;
            if (!stuck) begin
                bus_if.codec_ack   <= 1'b0;
                bus_if.codec_adpcm <= code_of(bus_if.codec_pcm);
                busy_cnt           <= 4'd6;
            end
        end else if (!bus_if.codec_ack) begin
            if (busy_cnt == 4'd0) bus_if.codec_ack <= 1'b1;
            else                  busy_cnt <= busy_cnt - 4'd1;
        end
    end

    // Packer monitor: logs each push toggle with its code and edge number
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            last_push <= 1'b0;
        end else if (bus_if.pack_push !== last_push) begin
            obs_code_q.push_back(bus_if.pack_adpcm);
            obs_cyc_q.push_back(cyc);
            last_push <= bus_if.pack_push;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        obs_code_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if (bus_if.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", bus_if.s_ready); end
        n_tests++; if (bus_if.codec_req !== 1'b0) begin n_fail++; $display("FAIL reset_codec_req: got %b want 0", bus_if.codec_req); end
        n_tests++; if (bus_if.codec_pcm !== 16'h0000) begin n_fail++; $display("FAIL reset_codec_pcm: got %h want 0000", bus_if.codec_pcm); end
        n_tests++; if (bus_if.pack_push !== 1'b0) begin n_fail++; $display("FAIL reset_pack_push: got %b want 0", bus_if.pack_push); end
        n_tests++; if (bus_if.pack_adpcm !== 4'h0) begin n_fail++; $display("FAIL reset_pack_adpcm: got %h want 0", bus_if.pack_adpcm); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single();
        int e0;
        clear_sb();
        @(negedge clk);
        bus_if.s_pcm = 16'h0100; bus_if.s_valid = 1'b1; e0 = cyc + 1;
        exp_q.push_back(4'h7);
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    n_tests++; if (bus_if.codec_pcm !== 16'h0100) begin n_fail++; $display("FAIL single_pcm_e1: got %h want 0100", bus_if.codec_pcm); end
                    n_tests++; if (bus_if.codec_req !== 1'b0) begin n_fail++; $display("FAIL single_req_e1: got %b want 0", bus_if.codec_req); end
                end
                2: begin
                    n_tests++; if (bus_if.codec_req !== 1'b1) begin n_fail++; $display("FAIL single_req_e2: got %b want 1", bus_if.codec_req); end
                end
                10: begin
                    n_tests++; if (bus_if.pack_adpcm !== 4'h0) begin n_fail++; $display("FAIL single_adpcm_e10: got %h want 0", bus_if.pack_adpcm); end
                end
                11: begin
                    n_tests++; if (bus_if.pack_adpcm !== 4'h7) begin n_fail++; $display("FAIL single_adpcm_e11: got %h want 7", bus_if.pack_adpcm); end
                    n_tests++; if (bus_if.pack_push !== 1'b0) begin n_fail++; $display("FAIL single_push_e11: got %b want 0", bus_if.pack_push); end
                end
                12: begin
                    n_tests++; if (bus_if.pack_push !== 1'b1) begin n_fail++; $display("FAIL single_push_e12: got %b want 1", bus_if.pack_push); end
                end
                default: ;
            endcase
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
        n_tests++;
        if (obs_code_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL single_count: got %0d pushes want 1", obs_code_q.size());
        end else if (obs_code_q[0] !== exp_q[0] || obs_cyc_q[0] != e0 + 12) begin
            n_fail++; $display("FAIL single_push: got %h at E%0d want %h at E12", obs_code_q[0], obs_cyc_q[0] - e0, exp_q[0]);
        end
    endtask

    task automatic test_burst();
        int   idx;
        logic saw_full;
        clear_sb();
        idx = 0; saw_full = 1'b0;
        for (int g = 0; g < 200 && idx < 10; g++) begin
            @(negedge clk);
            if (!bus_if.s_ready) begin
                saw_full = 1'b1;
                n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL burst_ready_level: got level %0d want 8", level); end
            end
            bus_if.s_pcm = smp_of(idx); bus_if.s_valid = 1'b1;
            if (bus_if.s_ready) begin
                exp_q.push_back(code_of(smp_of(idx)));
                idx++;
            end
        end
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        n_tests++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL burst_full_seen: got %b want 1", saw_full); end
        for (int g = 0; g < 300 && obs_code_q.size() < 10; g++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_tests++; if (obs_code_q.size() != 10) begin n_fail++; $display("FAIL burst_count: got %0d want 10", obs_code_q.size()); end
        for (int i = 0; i < 10 && i < obs_code_q.size(); i++) begin
            n_tests++; if (obs_code_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_code[%0d]: got %h want %h", i, obs_code_q[i], exp_q[i]); end
            if (i > 0) begin
                n_tests++; if (obs_cyc_q[i] - obs_cyc_q[i-1] != 12) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d want 12", i, obs_cyc_q[i] - obs_cyc_q[i-1]); end
            end
        end
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL burst_drain_level: got %0d want 0", level); end
    endtask

    task automatic test_full();
        int   e0, acc, rel;
        logic push_ref, toggled;
        clear_sb();
        bus_if.pack_full = 1'b1;
        @(negedge clk);
        bus_if.s_pcm = 16'h0A53; bus_if.s_valid = 1'b1; e0 = cyc + 1;
        exp_q.push_back(code_of(16'h0A53));
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        repeat (11) @(negedge clk);
        n_tests++; if (bus_if.pack_adpcm !== code_of(16'h0A53)) begin n_fail++; $display("FAIL full_capture: got %h want %h", bus_if.pack_adpcm, code_of(16'h0A53)); end
        push_ref = bus_if.pack_push; toggled = 1'b0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.pack_push !== push_ref) toggled = 1'b1;
            if (bus_if.s_ready) begin
                bus_if.s_pcm = smp_of(20 + acc); bus_if.s_valid = 1'b1;
                exp_q.push_back(code_of(smp_of(20 + acc)));
                acc++;
            end else begin
                bus_if.s_valid = 1'b0;
            end
        end
        bus_if.s_valid = 1'b0;
        n_tests++; if (toggled !== 1'b0 || obs_code_q.size() != 0) begin n_fail++; $display("FAIL full_hold: toggled %b pushes %0d want 0 0", toggled, obs_code_q.size()); end
        n_tests++; if (acc != 8) begin n_fail++; $display("FAIL full_accepted: got %0d want 8", acc); end
        n_tests++; if (level !== 4'd8 || bus_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_fifo: got level %0d ready %b want 8 0", level, bus_if.s_ready); end
        bus_if.pack_full = 1'b0; rel = cyc;
        @(negedge clk);
        n_tests++; if (obs_code_q.size() != 1 || obs_cyc_q[0] != rel + 1) begin n_fail++; $display("FAIL full_release: got %0d pushes want 1 one edge after release", obs_code_q.size()); end
        for (int g = 0; g < 300 && obs_code_q.size() < 9; g++) @(negedge clk);
        n_tests++; if (obs_code_q.size() != 9) begin n_fail++; $display("FAIL full_count: got %0d want 9", obs_code_q.size()); end
        for (int i = 0; i < 9 && i < obs_code_q.size(); i++) begin
            n_tests++; if (obs_code_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_code[%0d]: got %h want %h", i, obs_code_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int e0;
        clear_sb();
        stuck = 1'b1;
        @(negedge clk);
        bus_if.s_pcm = 16'h3C3C; bus_if.s_valid = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) begin
                n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_early: got %b want 0 at E17", err); end
            end
            if (k == 18) begin
                n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1 at E18", err); end
            end
        end
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (obs_code_q.size() != 0) begin n_fail++; $display("FAIL tmo_no_push: got %0d want 0", obs_code_q.size()); end
        bus_if.s_pcm = 16'h5A01; bus_if.s_valid = 1'b1;
        exp_q.push_back(code_of(16'h5A01));
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        for (int g = 0; g < 100 && obs_code_q.size() < 1; g++) @(negedge clk);
        n_tests++; if (obs_code_q.size() != 1 || obs_code_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL tmo_next_sample: got %0d pushes want 1 code %h", obs_code_q.size(), exp_q[0]); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: got %b want 0", err); end
    endtask

    task automatic test_enable();
        int          e0;
        logic [27:0] snap, now;
        clear_sb();
        @(negedge clk);
        bus_if.s_pcm = 16'h7E42; bus_if.s_valid = 1'b1; e0 = cyc + 1;
        exp_q.push_back(code_of(16'h7E42));
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        snap = 28'h0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            now = {bus_if.codec_req, bus_if.codec_pcm, bus_if.pack_push, bus_if.pack_adpcm, level, bus_if.s_ready, err};
            if (k == 8) begin
                snap = now;
                enable = 1'b0;
                bus_if.s_pcm = 16'hFFFF; bus_if.s_valid = 1'b1;
            end else if (k >= 9 && k <= 13) begin
                n_tests++; if (now !== snap) begin n_fail++; $display("FAIL enable_freeze_k%0d: got %h want %h", k, now, snap); end
                if (k == 13) begin
                    enable = 1'b1; bus_if.s_valid = 1'b0;
                end
            end
        end
        n_tests++;
        if (obs_code_q.size() != 1) begin
            n_fail++; $display("FAIL enable_count: got %0d want 1", obs_code_q.size());
        end else if (obs_code_q[0] !== exp_q[0] || obs_cyc_q[0] != e0 + 15) begin
            n_fail++; $display("FAIL enable_resume: got %h at E%0d want %h at E15", obs_code_q[0], obs_cyc_q[0] - e0, exp_q[0]);
        end
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL enable_no_write: got level %0d want 0", level); end
    endtask

    task automatic test_rst_mid();
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.s_pcm = smp_of(40 + i); bus_if.s_valid = 1'b1;
        end
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        n_tests++; if (level !== 4'd3) begin n_fail++; $display("FAIL rst_pre_level: got %0d want 3", level); end
        rstn = 1'b0;
        #1;
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
        n_tests++; if (bus_if.codec_req !== 1'b0 || bus_if.pack_push !== 1'b0) begin n_fail++; $display("FAIL rst_toggles: got req %b push %b want 0 0", bus_if.codec_req, bus_if.pack_push); end
        n_tests++; if (bus_if.codec_pcm !== 16'h0000) begin n_fail++; $display("FAIL rst_pcm: got %h want 0000", bus_if.codec_pcm); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        clear_sb();
        n_tests++; if (bus_if.s_ready !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL rst_release: got ready %b level %0d want 1 0", bus_if.s_ready, level); end
        bus_if.s_pcm = 16'h1234; bus_if.s_valid = 1'b1;
        exp_q.push_back(code_of(16'h1234));
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        for (int g = 0; g < 100 && obs_code_q.size() < 1; g++) @(negedge clk);
        n_tests++; if (obs_code_q.size() != 1 || obs_code_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rst_after: got %0d pushes want 1 code %h", obs_code_q.size(), exp_q[0]); end
    endtask

    // Scenario sequence
    initial begin
        bus_if.s_valid   = 1'b0;
        bus_if.s_pcm     = 16'h0000;
        bus_if.pack_full = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_single();
        test_burst();
        test_full();
        test_timeout();
        test_enable();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adpcm_enc_feeder.md
Name: adpcm_enc_feeder

Overview:
- Upstream sequencer for the adpcm codec in encode mode.
- Buffers 16-bit PCM samples from a valid/ready stream in a small FIFO.
- Presents one sample at a time to the codec using its toggle-req / level-ack handshake, and captures the resulting 4-bit code.
- Forwards each code to the nibble packer (adpcm_mono_byte) with a toggle push, honouring the packer's full flag.

Parameters:
- DEPTH, 8, FIFO depth in samples; power of two, minimum 2.
- TIMEOUT, 16, max cycles spent in BUSY+DONE per sample before abort.

Ports:
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- enable  input  1  synchronous run enable; low freezes all state
- s_valid  input  1  PCM sample valid
- s_ready  output  1  FIFO can accept a sample
- s_pcm  input  16  signed PCM sample
- codec_req  output  1  toggle request to codec (drives codec req)
- codec_ack  input  1  codec idle level (codec ack)
- codec_pcm  output  16  sample presented to codec (drives codec rx_pcm)
- codec_adpcm  input  4  codec result (codec tx_adpcm)
- pack_push  output  1  toggle push to packer
- pack_adpcm  output  4  nibble to packer (drives packer rx_adpcm)
- pack_full  input  1  packer full flag
- clr_err  input  1  clears err
- err  output  1  sticky timeout flag
- level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rstn low, asynchronous):
  - FIFO is empty and level = 0; s_ready = 1.
  - FSM is in S_IDLE.
  - codec_req = 0, codec_pcm = 0, pack_push = 0, pack_adpcm = 0, err = 0, timeout counter = 0.
- enable low: every register holds its value, including toggle levels, so no spurious edges reach neighbours. No FIFO writes or reads occur.
- FIFO:
  - s_ready = (level < DEPTH).
  - Write on enable & s_valid & s_ready.
  - Pop only on the S_IDLE->S_REQ transition.
  - Simultaneous write and pop: both take effect and level is unchanged.
  - Pointers wrap modulo DEPTH. Full is detected using level, not pointer equality.
- FSM, one transition per enabled cycle:
  - S_IDLE: if level != 0 and codec_ack = 1, load codec_pcm <= FIFO head, pop, go to S_REQ. Otherwise stay.
  - S_REQ: codec_req <= ~codec_req; clear timeout counter; go to S_BUSY. codec_pcm stays stable from S_REQ until the next pop.
  - S_BUSY: if codec_ack = 0, go to S_DONE.
  - S_DONE: if codec_ack = 1, pack_adpcm <= codec_adpcm, go to S_PUSH.
  - S_PUSH: if pack_full = 0, pack_push <= ~pack_push, go to S_IDLE. Otherwise stay; there is no timeout in S_PUSH.
- Timeout:
  - The counter increments on each cycle spent in S_BUSY or S_DONE.
  - When the counter reaches TIMEOUT: set err, drop the sample (no push, pack_adpcm unchanged), return to S_IDLE.
  - codec_req is not toggled back on abort.
- err: sticky. clr_err clears it on the next edge. If clr_err coincides with a new timeout, set wins.
- Nominal latency with an 8-state codec and an empty FIFO:
  - Sample accepted at edge E0.
  - S_REQ at E1; codec_req toggles at E2.
  - S_DONE at E4.
  - Code captured at E11; pack_push toggles at E12.
  - Sustained throughput is one sample per 12 cycles.
- codec_adpcm is sampled only in S_DONE with ack high; it is ignored at all other times.
- Reset mid-operation: immediate return to reset values. A toggle in flight is lost. Neighbours must be reset together.

Test Plan:
- Single sample 16'sh0100 into an empty FIFO, ideal codec model returning 4'h7 -> codec_pcm = 16'h0100 at E1, codec_req toggles at E2, pack_adpcm = 4'h7 at E11, pack_push toggles at E12, err = 0.
- Burst of 10 samples with DEPTH=8 and s_valid held -> s_ready drops when level = 8. All 10 codes are pushed in order, 12 cycles apart, with no loss or duplication.
- pack_full held high for 20 cycles in S_PUSH -> FSM holds and pack_push does not toggle. The push happens one cycle after pack_full falls. FIFO keeps accepting until full.
- Codec model never drops ack after req -> err sets after 16 cycles in S_BUSY and the FSM returns to S_IDLE. The next sample is processed normally. clr_err clears err.
- enable low for 5 cycles during S_DONE -> all outputs frozen and no toggles. Operation resumes exactly where it stopped.
- rstn pulsed low during S_BUSY with 3 samples queued -> level = 0, codec_req = 0, pack_push = 0 immediately. After release s_ready = 1.
